status_branch_unit: RTL and testbench

- Consumer end of the ALU status interface: takes the ALU's clocked flags (statusZ/N/V) and combinational flags (zout, nORv) plus the ALU result.
- Resolves the status-conditional and register/memory-indirect branches (bz/bn/bv, blezal, brv, jmxor) into a next-PC and a link write.
- Sits between execute and fetch. Stalls fetch while a memory-indirect jump fetches its target.

---
 rtl/status_branch_pkg.sv | 25 ++
 rtl/status_branch_if.sv | 18 +
 rtl/status_branch_cond.sv | 27 ++
 rtl/status_branch_unit.sv | 184 ++++++++++++++++++
 tb/tb_status_branch_unit.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/status_branch_pkg.sv
// Shared encodings for the status/indirect branch unit:
// branch opcodes, FSM states and default timing constants.
package status_branch_pkg;

  typedef enum logic [2:0] {
    OP_NONE   = 3'b000,
    OP_BZ     = 3'b001,
    OP_BN     = 3'b010,
    OP_BV     = 3'b011,
    OP_BLEZAL = 3'b100,
    OP_BRV    = 3'b101,
    OP_JMXOR  = 3'b110,
    OP_RSVD   = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_LINK     = 2'd2
  } state_e;

  localparam int LINK_REG_DEF    = 31;
  localparam int MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/status_branch_if.sv
// Data-memory read port used by jmxor to fetch its target word.
// master = branch unit, slave = memory.
interface status_branch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  modport master (
    output mem_req, mem_addr,
    input  mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/status_branch_cond.sv
// Branch condition decode: br_op plus ALU flags -> take.
// jmxor and none/reserved never report take here.
module status_branch_cond
  import status_branch_pkg::*;
(
  input  br_op_e op_i,
  input  logic   status_z_i,
  input  logic   status_n_i,
  input  logic   status_v_i,
  input  logic   norv_i,
  output logic   take_o
);

  // one-hot style decode of the taking condition
  always_comb begin
    take_o = 1'b0;
    unique case (1'b1)
      (op_i == OP_BZ):     take_o = status_z_i;
      (op_i == OP_BN):     take_o = status_n_i;
      (op_i == OP_BV):     take_o = status_v_i;
      (op_i == OP_BLEZAL): take_o = norv_i;
      (op_i == OP_BRV):    take_o = 1'b1;
      default:             take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_branch_unit.sv
// Status-conditional and indirect branch resolution between EX and IF.
// Optional counters enabled by STATUS_BRANCH_STATS_EN.
module status_branch_unit
  import status_branch_pkg::*;
#(
  parameter int LINK_REG    = LINK_REG_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [2:0]  br_op,
  input  logic        link_en,
  input  logic [31:0] pc4,
  input  logic [31:0] br_target,
  input  logic [31:0] alu_sum,
  input  logic        statusZ,
  input  logic        statusN,
  input  logic        statusV,
  input  logic        zout,
  input  logic        nORv,
  status_branch_if.master mem,
  output logic [31:0] pc_next,
  output logic        pc_load,
  output logic        stall,
  output logic        link_we,
  output logic [4:0]  link_addr,
  output logic [31:0] link_data,
  output logic        br_fault
`ifdef STATUS_BRANCH_STATS_EN
  ,
  output logic [15:0] taken_cnt,
  output logic [7:0]  fault_cnt
`endif
);

  localparam logic [4:0] LINK_A  = 5'(LINK_REG);
  localparam logic [3:0] TO_LAST = 4'(MEM_TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] pc_next_q;
  logic [31:0] addr_q;
  logic [31:0] link_q;
  logic        lnk_en_q;
  logic [3:0]  cnt_q;
  logic        fault_q;

  br_op_e      op;
  logic        take;
  logic        pc_load_d;
  logic [31:0] pc_next_d;
  logic        stall_d;
  logic        mem_req_d;
  logic [31:0] mem_addr_d;
  logic        timeout;
  logic        unused_zout;

  assign op          = br_op_e'(br_op);
  assign unused_zout = zout;

  status_branch_cond u_cond (
    .op_i       (op),
    .status_z_i (statusZ),
    .status_n_i (statusN),
    .status_v_i (statusV),
    .norv_i     (nORv),
    .take_o     (take)
  );

  assign timeout = (state_q == S_MEM_WAIT)
                 && !mem.mem_rvalid
                 && (cnt_q == TO_LAST);

  // same-cycle redirect, stall and memory request
  always_comb begin
    pc_load_d  = 1'b0;
    pc_next_d  = pc_next_q;
    stall_d    = 1'b0;
    mem_req_d  = 1'b0;
    mem_addr_d = addr_q;
    if (!reset) begin
      unique case (state_q)
        S_IDLE: begin
          if (ex_valid) begin
            if (op == OP_JMXOR) begin
              mem_req_d  = 1'b1;
              mem_addr_d = alu_sum;
              stall_d    = 1'b1;
            end else if (take) begin
              pc_load_d = 1'b1;
              pc_next_d = (op == OP_BRV)
                        ? alu_sum : br_target;
            end
          end
        end
        S_MEM_WAIT: begin
          stall_d   = 1'b1;
          mem_req_d = 1'b1;
          if (mem.mem_rvalid) begin
            pc_load_d = 1'b1;
            pc_next_d = mem.mem_rdata ^ addr_q;
          end
        end
        S_LINK: stall_d = 1'b1;
        default: ;
      endcase
    end
  end

  // FSM and latched operands
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_next_q <= '0;
      addr_q    <= '0;
      link_q    <= '0;
      lnk_en_q  <= 1'b0;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
    end else begin
      if (pc_load_d) pc_next_q <= pc_next_d;
      unique case (state_q)
        S_IDLE: begin
          if (ex_valid) begin
            if (op == OP_JMXOR) begin
              addr_q   <= alu_sum;
              link_q   <= pc4;
              lnk_en_q <= link_en;
              cnt_q    <= '0;
              state_q  <= S_MEM_WAIT;
            end else if (take && link_en) begin
              link_q  <= pc4;
              state_q <= S_LINK;
            end
          end
        end
        S_MEM_WAIT: begin
          if (mem.mem_rvalid) begin
            state_q <= lnk_en_q ? S_LINK : S_IDLE;
          end else if (timeout) begin
            fault_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_LINK:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc_next      = pc_next_d;
  assign pc_load      = pc_load_d;
  assign stall        = stall_d;
  assign mem.mem_req  = mem_req_d;
  assign mem.mem_addr = mem_addr_d;
  assign link_we      = (state_q == S_LINK) && !reset;
  assign link_addr    = LINK_A;
  assign link_data    = link_q;
  assign br_fault     = fault_q;

`ifdef STATUS_BRANCH_STATS_EN
  logic [15:0] taken_q;
  logic [7:0]  fault_cnt_q;

  // saturating redirect and timeout counters
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_q     <= '0;
      fault_cnt_q <= '0;
    end else begin
      if (pc_load_d && (taken_q != '1))
        taken_q <= taken_q + 16'd1;
      if (timeout && (fault_cnt_q != '1))
        fault_cnt_q <= fault_cnt_q + 8'd1;
    end
  end

  assign taken_cnt = taken_q;
  assign fault_cnt = fault_cnt_q;
`endif

endmodule

// File: tb/tb_status_branch_unit.sv
// Directed scoreboard bench for status_branch_unit.
// Expected redirects/links/faults are queued; a monitor pops them.
module tb_status_branch_unit;

  localparam int K_PC    = 0;
  localparam int K_LINK  = 1;
  localparam int K_FAULT = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  br_op;
  logic        link_en;
  logic [31:0] pc4, br_target, alu_sum;
  logic        statusZ, statusN, statusV, zout, nORv;
  logic [31:0] pc_next;
  logic        pc_load, stall, link_we;
  logic [4:0]  link_addr;
  logic [31:0] link_data;
  logic        br_fault;
`ifdef STATUS_BRANCH_STATS_EN
  logic [15:0] taken_cnt;
  logic [7:0]  fault_cnt;
`endif

  status_branch_if mif();

  status_branch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .ex_valid  (ex_valid),
    .br_op     (br_op),
    .link_en   (link_en),
    .pc4       (pc4),
    .br_target (br_target),
    .alu_sum   (alu_sum),
    .statusZ   (statusZ),
    .statusN   (statusN),
    .statusV   (statusV),
    .zout      (zout),
    .nORv      (nORv),
    .mem       (mif),
    .pc_next   (pc_next),
    .pc_load   (pc_load),
    .stall     (stall),
    .link_we   (link_we),
    .link_addr (link_addr),
    .link_data (link_data),
    .br_fault  (br_fault)
`ifdef STATUS_BRANCH_STATS_EN
    ,
    .taken_cnt (taken_cnt),
    .fault_cnt (fault_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input int kind,
                         input logic [31:0] act,
                         input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event got %h want none",
               name, act);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val !== act) begin
        errors++;
        $display("FAIL %s got kind %0d val %h want kind %0d val %h",
                 name, kind, act, e.kind, e.val);
      end
    end
  endtask

  task automatic push(input int kind, input logic [31:0] v);
    exp_t e;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  // monitor: every redirect, link write or new fault consumes one entry
  logic fault_prev = 1'b0;
  always @(negedge clk) begin
    if (pc_load) pop_chk(K_PC, pc_next, "pc_load");
    if (link_we) begin
      pop_chk(K_LINK, link_data, "link_we");
      chk("link_addr", {27'd0, link_addr}, 32'd31);
      chk("link_stall", {31'd0, stall}, 32'd1);
    end
    if (br_fault && !fault_prev) pop_chk(K_FAULT, 32'd0, "br_fault");
    fault_prev = br_fault;
  end

  initial begin
    reset = 1'b1; ex_valid = 1'b0; br_op = 3'b000; link_en = 1'b0;
    pc4 = '0; br_target = '0; alu_sum = '0;
    statusZ = 0; statusN = 0; statusV = 0; zout = 0; nORv = 0;
    mif.mem_rdata = '0; mif.mem_rvalid = 1'b0;

    // reset state
    step(); step();
    @(negedge clk);
    chk("rst_pc_load", {31'd0, pc_load}, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_mem_req", {31'd0, mif.mem_req}, 0);
    chk("rst_pc_next", pc_next, 0);
    chk("rst_link_addr", {27'd0, link_addr}, 31);
    chk("rst_fault", {31'd0, br_fault}, 0);
    step(); reset = 1'b0;

    // bz taken; flag drop next cycle is irrelevant
    step();
    ex_valid = 1; br_op = 3'b001; statusZ = 1; br_target = 32'h40;
    push(K_PC, 32'h40);
    step(); statusZ = 0;
    @(negedge clk);
    chk("bz_no_link", {31'd0, link_we}, 0);

    // bz not taken, pc_next holds
    step();
    ex_valid = 1; br_op = 3'b001; statusZ = 0; br_target = 32'h80;
    @(negedge clk);
    chk("bz_nt_load", {31'd0, pc_load}, 0);
    chk("bz_nt_hold", pc_next, 32'h40);

    // blezal with link; ex_valid during LINK ignored
    step();
    ex_valid = 1; br_op = 3'b100; nORv = 1; link_en = 1;
    pc4 = 32'h104; br_target = 32'h200;
    push(K_PC, 32'h200);
    push(K_LINK, 32'h104);
    step();
    ex_valid = 1; br_op = 3'b001; statusZ = 1; link_en = 0;
    br_target = 32'h999; nORv = 0;
    step(); statusZ = 0;
    @(negedge clk);
    chk("after_link_stall", {31'd0, stall}, 0);

    // brv
    step();
    ex_valid = 1; br_op = 3'b101; alu_sum = 32'h1000;
    push(K_PC, 32'h1000);
    step();
    @(negedge clk);
    chk("brv_idle_stall", {31'd0, stall}, 0);

    // bn taken, bv not taken, reserved nothing
    step();
    ex_valid = 1; br_op = 3'b010; statusN = 1; br_target = 32'h88;
    push(K_PC, 32'h88);
    step(); statusN = 0;
    ex_valid = 1; br_op = 3'b011; statusV = 0; br_target = 32'h99;
    step();
    ex_valid = 1; br_op = 3'b111; statusZ = 1; statusV = 1;
    step(); statusZ = 0; statusV = 0;

    // jmxor, rvalid on third wait cycle
    ex_valid = 1; br_op = 3'b110; alu_sum = 32'h10; link_en = 0;
    @(negedge clk);
    chk("jx_req0", {31'd0, mif.mem_req}, 1);
    chk("jx_addr0", mif.mem_addr, 32'h10);
    chk("jx_stall0", {31'd0, stall}, 1);
    step(); alu_sum = 32'hDEAD;
    @(negedge clk);
    chk("jx_addr1", mif.mem_addr, 32'h10);
    chk("jx_stall1", {31'd0, stall}, 1);
    step();
    @(negedge clk);
    chk("jx_addr2", mif.mem_addr, 32'h10);
    chk("jx_req2", {31'd0, mif.mem_req}, 1);
    step();
    mif.mem_rvalid = 1; mif.mem_rdata = 32'h0000_0F10;
    push(K_PC, 32'h0000_0F00);
    step(); mif.mem_rvalid = 0;
    @(negedge clk);
    chk("jx_done_stall", {31'd0, stall}, 0);
    chk("jx_done_req", {31'd0, mif.mem_req}, 0);

    // jmxor with link, rvalid on first wait cycle
    step();
    ex_valid = 1; br_op = 3'b110; alu_sum = 32'h20;
    link_en = 1; pc4 = 32'h300;
    step(); link_en = 0;
    mif.mem_rvalid = 1; mif.mem_rdata = 32'h0000_1020;
    push(K_PC, 32'h1000);
    push(K_LINK, 32'h300);
    step(); mif.mem_rvalid = 0;
    step();

    // jmxor timeout
    ex_valid = 1; br_op = 3'b110; alu_sum = 32'h30;
    push(K_FAULT, 32'd0);
    for (int i = 0; i < 15; i++) step();
    @(negedge clk);
    chk("to_w15_fault", {31'd0, br_fault}, 0);
    chk("to_w15_stall", {31'd0, stall}, 1);
    step();
    @(negedge clk);
    chk("to_fault", {31'd0, br_fault}, 1);
    chk("to_stall", {31'd0, stall}, 0);
    chk("to_req", {31'd0, mif.mem_req}, 0);
    step();
    mif.mem_rvalid = 1; mif.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_rvalid", {31'd0, pc_load}, 0);
    step(); mif.mem_rvalid = 0;

    // still works after a fault
    ex_valid = 1; br_op = 3'b001; statusZ = 1; br_target = 32'h44;
    push(K_PC, 32'h44);
    step(); statusZ = 0;

    // reset during MEM_WAIT
    ex_valid = 1; br_op = 3'b110; alu_sum = 32'h50;
    step();
    step(); reset = 1;
    @(negedge clk);
    chk("rw_pc_load", {31'd0, pc_load}, 0);
    step(); reset = 0;
    @(negedge clk);
    chk("rw_req", {31'd0, mif.mem_req}, 0);
    chk("rw_stall", {31'd0, stall}, 0);
    chk("rw_fault", {31'd0, br_fault}, 0);
    chk("rw_addr", mif.mem_addr, 0);
    chk("rw_pc_next", pc_next, 0);
    step();
    ex_valid = 1; br_op = 3'b101; alu_sum = 32'h2000;
    push(K_PC, 32'h2000);
    step(); step(); step();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
